// File: rtl/traffic_light_fsm_pkg.sv
// Shared definitions for the intersection sequencer and the interval-parameter store:
// store addresses, one-hot light encodings, the FSM state type and its output decode.
package traffic_light_fsm_pkg;

    localparam int LOAD_LAT_DEF = 2;

    localparam logic [1:0] BASE_ADD = 2'b00;
    localparam logic [1:0] EXTD_ADD = 2'b01;
    localparam logic [1:0] YELL_ADD = 2'b10;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    typedef enum logic [2:0] {
        MAIN_GRN = 3'd0,
        MAIN_EXT = 3'd1,
        MAIN_YEL = 3'd2,
        SIDE_GRN = 3'd3,
        SIDE_YEL = 3'd4,
        WALK     = 3'd5
    } state_t;

    typedef struct packed {
        logic [1:0] addr;
        logic [2:0] main;
        logic [2:0] side;
        logic       walk;
    } light_out_t;

    function automatic light_out_t state_outputs(input state_t s);
        light_out_t o;
        o = '{addr: BASE_ADD, main: GRN, side: RED, walk: 1'b0};
        case (s)
            MAIN_GRN: o = '{addr: BASE_ADD, main: GRN, side: RED, walk: 1'b0};
            MAIN_EXT: o = '{addr: EXTD_ADD, main: GRN, side: RED, walk: 1'b0};
            MAIN_YEL: o = '{addr: YELL_ADD, main: YEL, side: RED, walk: 1'b0};
            SIDE_GRN: o = '{addr: BASE_ADD, main: RED, side: GRN, walk: 1'b0};
            SIDE_YEL: o = '{addr: YELL_ADD, main: RED, side: YEL, walk: 1'b0};
            WALK:     o = '{addr: EXTD_ADD, main: RED, side: RED, walk: 1'b1};
            default:  o = '{addr: BASE_ADD, main: GRN, side: RED, walk: 1'b0};
        endcase
        return o;
    endfunction

    // An unprogrammed (0) or defaulted (15) store entry still yields a one-tick dwell.
    function automatic logic [3:0] sanitize_interval(input logic [3:0] v);
        return (v == 4'd0 || v == 4'd15) ? 4'd1 : v;
    endfunction

endpackage

// File: rtl/traffic_light_fsm_interval.sv
// Interval timer: waits out the store read latency after each start, loads the
// sanitized interval, then counts 1 Hz ticks down to a single-cycle expire pulse.
module interval_timer
    import traffic_light_fsm_pkg::*;
#(
    parameter int LOAD_LAT = LOAD_LAT_DEF
) (
    input  logic       clk,
    input  logic       sys_reset_n,
    input  logic       start,
    input  logic       tick,
    input  logic [3:0] value,
    output logic       expire,
    output logic [3:0] cnt
);

    localparam int WW = (LOAD_LAT < 1) ? 1 : $clog2(LOAD_LAT + 1);

    logic [WW-1:0] r_wait;
    logic          r_loading;
    logic [3:0]    r_cnt;

    // NOTE: start outranks everything, so an expiry or a reprogram always restarts the wait.
    always_ff @(posedge clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_wait    <= WW'(LOAD_LAT);
            r_loading <= 1'b1;
            r_cnt     <= 4'd0;
        end else if (start) begin
            r_wait    <= WW'(LOAD_LAT);
            r_loading <= 1'b1;
            r_cnt     <= 4'd0;
        end else if (r_loading) begin
            if (r_wait != '0) begin
                r_wait <= r_wait - WW'(1);
            end else begin
                r_loading <= 1'b0;
                r_cnt     <= sanitize_interval(value);
            end
        end else if (tick && r_cnt > 4'd1) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign expire = tick & ~r_loading & (r_cnt == 4'd1);
    assign cnt    = r_cnt;

endmodule

// File: rtl/traffic_light_fsm.sv
// Intersection light sequencer: six-state FSM with sensor/walk latches and registered
// lights; freezes at MAIN_GRN while the interval store is being reprogrammed.
module traffic_light_fsm
    import traffic_light_fsm_pkg::*;
#(
    parameter int LOAD_LAT = LOAD_LAT_DEF
) (
    input  logic       clk,
    input  logic       sys_reset_n,
    input  logic       one_hz_en,
    input  logic       sensor,
    input  logic       walk_req,
    input  logic       prg_sync_in,
    input  logic [3:0] interval_value,
    output logic [1:0] interval_address,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk_light,
    output logic [3:0] timer_cnt
);

    state_t     r_state, w_next;
    light_out_t r_out;
    logic       r_sensor_latch, r_walk_latch;
    logic       w_expire, w_start, w_enter;

    interval_timer #(.LOAD_LAT(LOAD_LAT)) u_timer (
        .clk         (clk),
        .sys_reset_n (sys_reset_n),
        .start       (w_start),
        .tick        (one_hz_en),
        .value       (interval_value),
        .expire      (w_expire),
        .cnt         (timer_cnt)
    );

    // NOTE: w_next gets its default first so no path through this block infers a latch.
    always_comb begin
        w_next = r_state;
        if (prg_sync_in) begin
            w_next = MAIN_GRN;
        end else if (w_expire) begin
            case (r_state)
                MAIN_GRN: w_next = r_sensor_latch ? MAIN_EXT : MAIN_YEL;
                MAIN_EXT: w_next = MAIN_YEL;
                MAIN_YEL: w_next = SIDE_GRN;
                SIDE_GRN: w_next = SIDE_YEL;
                SIDE_YEL: w_next = r_walk_latch ? WALK : MAIN_GRN;
                WALK:     w_next = MAIN_GRN;
                default:  w_next = MAIN_GRN;
            endcase
        end
    end

    // Every expiry leaves its state, so an expiry outside reprogramming is a state entry.
    assign w_enter = w_expire & ~prg_sync_in;
    assign w_start = prg_sync_in | w_expire;

    always_ff @(posedge clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_state <= MAIN_GRN;
            r_out   <= state_outputs(MAIN_GRN);
        end else begin
            r_state <= w_next;
            r_out   <= state_outputs(w_next);
        end
    end

    always_ff @(posedge clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_sensor_latch <= 1'b0;
            r_walk_latch   <= 1'b0;
        end else if (!prg_sync_in) begin
            r_sensor_latch <= (r_sensor_latch | (sensor & (r_state == MAIN_GRN || r_state == MAIN_EXT)))
                              & ~(w_enter & (w_next == SIDE_GRN));
            r_walk_latch   <= (r_walk_latch | (walk_req & (r_state != WALK)))
                              & ~(w_enter & (w_next == WALK));
        end
    end

    assign interval_address = r_out.addr;
    assign main_light       = r_out.main;
    assign side_light       = r_out.side;
    assign walk_light       = r_out.walk;

endmodule

// File: doc/traffic_light_fsm.md
Name: traffic_light_fsm

Overview:
- Intersection light sequencer. Sits directly downstream of the interval-parameter store.
- Drives the store's interval_address and loads the 4-bit interval it returns into a seconds countdown.
- Sequences main/side/walk lights, with a side-street sensor extension and a latched pedestrian phase.
- Freezes and restarts whenever reprogramming is in progress.

Parameters:
- LOAD_LAT, 2, cycles from interval_address change to a valid interval_value (address register plus the store's registered output).

Ports:
- clk  in  1  system clock.
- sys_reset_n  in  1  asynchronous, active-low reset.
- one_hz_en  in  1  single-cycle 1 Hz tick; the countdown decrements only on this.
- sensor  in  1  side-street vehicle present; level input, sampled.
- walk_req  in  1  pedestrian button; pulse, latched.
- prg_sync_in  in  1  reprogramming in progress (same signal the store sees).
- interval_value  in  4  interval returned by the store, in seconds.
- interval_address  out  2  00 BASE, 01 EXTD, 10 YELL; never drives 11.
- main_light  out  3  {R,Y,G}, one-hot.
- side_light  out  3  {R,Y,G}, one-hot.
- walk_light  out  1  walk indication.
- timer_cnt  out  4  remaining seconds, for debug.

Behaviour:
- Reset (async assert, sync release): state MAIN_GRN; load pending; main_light=001; side_light=100; walk_light=0; interval_address=00; timer_cnt=0; sensor and walk latches cleared.
- States, with address, lights, and exit rule:
  - MAIN_GRN: BASE; main G, side R. On expiry go to MAIN_EXT if the sensor latch is set, else MAIN_YEL.
  - MAIN_EXT: EXTD; main G, side R. On expiry go to MAIN_YEL.
  - MAIN_YEL: YELL; main Y, side R. On expiry go to SIDE_GRN.
  - SIDE_GRN: BASE; main R, side G. Clear the sensor latch on entry. On expiry go to SIDE_YEL.
  - SIDE_YEL: YELL; main R, side Y. On expiry go to WALK if the walk latch is set, else MAIN_GRN.
  - WALK: EXTD; both R, walk_light=1. Clear the walk latch on entry. On expiry go to MAIN_GRN.
- Lights and interval_address are registered and change in the same cycle as the state.
- Load phase, on every state entry:
  - Hold the countdown for LOAD_LAT cycles.
  - On the following cycle, timer_cnt <= interval_value.
  - If interval_value is 0 or 15, substitute 1; this covers an invalid or unprogrammed store.
  - Ticks arriving during the load phase are ignored.
- Countdown:
  - On one_hz_en with timer_cnt>1: decrement.
  - On one_hz_en with timer_cnt==1: expiry; the transition happens in that cycle.
  - Visible dwell is therefore interval_value ticks, plus up to one tick of phase error.
- sensor latch: set on any cycle where sensor=1 while in MAIN_GRN or MAIN_EXT.
- walk latch: set on any walk_req=1 outside WALK. A request during WALK is dropped.
- A set and a clear of the same latch in the same cycle: the clear wins.
- prg_sync_in=1:
  - Force state to MAIN_GRN with outputs at their reset values.
  - Keep load pending and ignore ticks.
  - Leave the latches untouched.
  - On the first cycle with prg_sync_in=0, begin the LOAD_LAT wait, so newly programmed values are picked up.
- Reset asserted mid-interval: immediate return to the reset state. No partial yellow is required.
- Invariant: main and side are never both non-red.

Decomposition:
- Shared package (also imported by the parameter store):
  - address constants BASE_ADD, EXTD_ADD, YELL_ADD;
  - light encodings RED=100, YEL=010, GRN=001;
  - state enum (3-bit) for the six states.
- One sub-module, interval_timer, owns:
  - the load-pending counter (LOAD_LAT);
  - the 4-bit countdown;
  - the 0/15 substitution;
  - the expire pulse.
- Its interface: start, tick, value, expire, cnt.
- The top level keeps the FSM, the latches and the output registers.

Test Plan:
- Defaults 6/3/2, no sensor, no walk, tick every 10 cycles -> cycle MAIN_GRN 6 ticks, MAIN_YEL 2, SIDE_GRN 6, SIDE_YEL 2, repeat; MAIN_EXT and WALK never entered.
- Sensor pulsed 1 cycle during MAIN_GRN -> MAIN_EXT entered for 3 ticks after MAIN_GRN; a pulse during SIDE_GRN has no effect.
- walk_req pulse during MAIN_YEL -> after SIDE_YEL, WALK for 3 ticks with both lights red and walk_light=1; a second pulse during WALK is ignored.
- interval_value forced to 15 (store default branch) in MAIN_YEL -> dwell of 1 tick, then SIDE_GRN.
- prg_sync_in high for 20 cycles mid-SIDE_GRN with BASE reprogrammed to 9 -> outputs held at main G/side R; after release, MAIN_GRN lasts 9 ticks.
- sys_reset_n pulsed low for 3 ns mid-MAIN_EXT (async, off clock edge) -> outputs return to reset values immediately; latches are cleared; the sequence restarts at MAIN_GRN.
